// File: rtl/rotate_pkg.sv
// Shared types for the rotating frame-buffer address generator.
package rotate_pkg;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_mode_t;

    typedef enum logic {
        MODE_IDLE    = 1'b0,
        MODE_PENDING = 1'b1
    } mode_state_t;

    typedef struct packed {
        rot_mode_t rot;
        logic      mirror;
    } mode_cfg_t;

    // Quarter turns swap the view width and height.
    function automatic logic is_transposed(input rot_mode_t r);
        return (r == ROT_90) || (r == ROT_270);
    endfunction

endpackage

// File: rtl/rotate_mode_ctrl.sv
// Mode request handshake: shadows requests and applies them only at frame start.
module rotate_mode_ctrl
    import rotate_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  logic      i_frame_start,
    input  logic      i_req,
    input  mode_cfg_t i_cfg,
    output logic      o_busy,
    output mode_cfg_t o_cfg_c
);

    mode_state_t r_state;
    mode_state_t w_state_nxt;
    mode_cfg_t   r_shadow;
    mode_cfg_t   w_shadow_nxt;
    mode_cfg_t   r_active;
    mode_cfg_t   w_active_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= MODE_IDLE;
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
        end
    end

    // o_cfg_c is the mode the current input cycle must use: the shadow wins on
    // the frame-start cycle that retires a request captured earlier.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active;
        o_cfg_c      = r_active;
        case (r_state)
            MODE_IDLE: begin
                if (i_req) begin
                    w_shadow_nxt = i_cfg;
                    w_state_nxt  = MODE_PENDING;
                end
            end
            MODE_PENDING: begin
                if (i_frame_start) begin
                    w_active_nxt = r_shadow;
                    o_cfg_c      = r_shadow;
                    w_state_nxt  = MODE_IDLE;
                end
                if (i_req) begin
                    w_shadow_nxt = i_cfg;
                    w_state_nxt  = MODE_PENDING;
                end
            end
            default: w_state_nxt = MODE_IDLE;
        endcase
    end

    assign o_busy = (r_state == MODE_PENDING);

endmodule

// File: rtl/rotate_addr_gen.sv
// Maps output-view coordinates to row-major source addresses under rotation/mirror,
// through a fixed three-stage pipeline.
module rotate_addr_gen
    import rotate_pkg::*;
#(
    parameter int unsigned SRC_W   = 320,
    parameter int unsigned SRC_H   = 240,
    parameter int unsigned PIXEL_W = 16,
    parameter int unsigned ADDR_W  = $clog2(SRC_W * SRC_H)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                data_valid_in,
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic [1:0]          mode_in,
    input  logic                mirror_in,
    input  logic                mode_req_in,
    output logic                mode_busy_out,
    output logic [PIXEL_W-1:0]  pixel_out,
    output logic [ADDR_W-1:0]   pixel_addr_out,
    output logic                in_bounds_out,
    output logic                data_valid_out
);

    localparam int unsigned CRD_W = 12;

    logic          w_frame_start;
    mode_cfg_t     w_req_cfg;
    mode_cfg_t     w_cfg;
    logic [CRD_W-1:0] w_vw, w_vh, w_x, w_y, w_xm, w_row, w_col;
    logic          w_in_bounds;

    logic [CRD_W-1:0]   r_s1_row, r_s1_col;
    logic               r_s1_inb, r_s1_valid;
    logic [PIXEL_W-1:0] r_s1_pixel;
    logic [ADDR_W-1:0]  r_s2_prod;
    logic [CRD_W-1:0]   r_s2_col;
    logic               r_s2_inb, r_s2_valid;
    logic [PIXEL_W-1:0] r_s2_pixel;

    assign w_frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign w_req_cfg     = '{rot: rot_mode_t'(mode_in), mirror: mirror_in};

    rotate_mode_ctrl u_mode_ctrl (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .i_frame_start (w_frame_start),
        .i_req         (mode_req_in),
        .i_cfg         (w_req_cfg),
        .o_busy        (mode_busy_out),
        .o_cfg_c       (w_cfg)
    );

    // Stage 1 logic: bounds on raw coordinates, then mirror, then rotate.
    always_comb begin
        w_vw        = is_transposed(w_cfg.rot) ? CRD_W'(SRC_H) : CRD_W'(SRC_W);
        w_vh        = is_transposed(w_cfg.rot) ? CRD_W'(SRC_W) : CRD_W'(SRC_H);
        w_x         = CRD_W'(hcount_in);
        w_y         = CRD_W'(vcount_in);
        w_in_bounds = (w_x < w_vw) && (w_y < w_vh);
        w_xm        = w_cfg.mirror ? (w_vw - CRD_W'(1) - w_x) : w_x;
        w_row       = '0;
        w_col       = '0;
        if (w_in_bounds) begin
            case (w_cfg.rot)
                ROT_0: begin
                    w_row = w_y;
                    w_col = w_xm;
                end
                ROT_90: begin
                    w_row = CRD_W'(SRC_H - 1) - w_xm;
                    w_col = w_y;
                end
                ROT_180: begin
                    w_row = CRD_W'(SRC_H - 1) - w_y;
                    w_col = CRD_W'(SRC_W - 1) - w_xm;
                end
                ROT_270: begin
                    w_row = w_xm;
                    w_col = CRD_W'(SRC_W - 1) - w_y;
                end
                default: begin
                    w_row = '0;
                    w_col = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_row       <= '0;
            r_s1_col       <= '0;
            r_s1_inb       <= 1'b0;
            r_s1_valid     <= 1'b0;
            r_s1_pixel     <= '0;
            r_s2_prod      <= '0;
            r_s2_col       <= '0;
            r_s2_inb       <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_s2_pixel     <= '0;
            pixel_addr_out <= '0;
            in_bounds_out  <= 1'b0;
            data_valid_out <= 1'b0;
            pixel_out      <= '0;
        end else begin
            r_s1_row       <= w_row;
            r_s1_col       <= w_col;
            r_s1_inb       <= w_in_bounds;
            r_s1_valid     <= data_valid_in;
            r_s1_pixel     <= pixel_in;
            r_s2_prod      <= ADDR_W'(r_s1_row) * ADDR_W'(SRC_W);
            r_s2_col       <= r_s1_col;
            r_s2_inb       <= r_s1_inb;
            r_s2_valid     <= r_s1_valid;
            r_s2_pixel     <= r_s1_pixel;
            pixel_addr_out <= r_s2_prod + ADDR_W'(r_s2_col);
            in_bounds_out  <= r_s2_inb;
            data_valid_out <= r_s2_valid;
            pixel_out      <= r_s2_pixel;
        end
    end

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Directed bench for rotate_addr_gen: mapping table, mode handshake, streaming and reset.
module tb_rotate_addr_gen;

    logic        clk_in;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic [15:0] pixel_in;
    logic [1:0]  mode_in;
    logic        mirror_in;
    logic        mode_req_in;
    logic        mode_busy_out;
    logic [15:0] pixel_out;
    logic [16:0] pixel_addr_out;
    logic        in_bounds_out;
    logic        data_valid_out;

    int n_assert = 0;
    int n_fail   = 0;

    rotate_addr_gen dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .pixel_in       (pixel_in),
        .mode_in        (mode_in),
        .mirror_in      (mirror_in),
        .mode_req_in    (mode_req_in),
        .mode_busy_out  (mode_busy_out),
        .pixel_out      (pixel_out),
        .pixel_addr_out (pixel_addr_out),
        .in_bounds_out  (in_bounds_out),
        .data_valid_out (data_valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int m;
        int mir;
        int h;
        int v;
        int addr;
        int inb;
    } vec_t;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        hcount_in     = '0;
        vcount_in     = '0;
        data_valid_in = 1'b0;
        pixel_in      = '0;
        mode_req_in   = 1'b0;
    endtask

    task automatic drive(input int h, input int v, input logic [15:0] pix);
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_valid_in = 1'b1;
        pixel_in      = pix;
    endtask

    // One valid coordinate, then wait out the pipeline and capture the result.
    task automatic run_vec(input int h, input int v, input logic [15:0] pix,
                           output logic [16:0] a, output logic ib,
                           output logic [15:0] po, output logic dv);
        drive(h, v, pix);
        cyc();
        idle();
        cyc();
        cyc();
        a  = pixel_addr_out;
        ib = in_bounds_out;
        po = pixel_out;
        dv = data_valid_out;
    endtask

    task automatic set_mode(input int m, input int mir);
        idle();
        mode_in     = 2'(m);
        mirror_in   = 1'(mir);
        mode_req_in = 1'b1;
        cyc();
        mode_req_in = 1'b0;
        drive(0, 0, 16'h0);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        idle();
        mode_in   = '0;
        mirror_in = 1'b0;
        cyc();
        cyc();
        n_assert++; if (data_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %0b expected 0", data_valid_out); end
        n_assert++; if (pixel_addr_out !== 17'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", pixel_addr_out); end
        n_assert++; if (in_bounds_out !== 1'b0) begin n_fail++; $display("FAIL reset_inb: got %0b expected 0", in_bounds_out); end
        n_assert++; if (pixel_out !== 16'd0) begin n_fail++; $display("FAIL reset_pix: got %0h expected 0", pixel_out); end
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", mode_busy_out); end
        rst_n_in = 1'b1;
        cyc();
    endtask

    task automatic test_mapping();
        vec_t vt [18];
        int cur_m, cur_mir;
        logic [16:0] a;
        logic ib, dv;
        logic [15:0] po, pix;
        vt = '{
            '{0, 0,   5,   2,   645, 1},
            '{0, 0, 319, 239, 76799, 1},
            '{0, 0, 320,   0,     0, 0},
            '{0, 0,   0, 240,     0, 0},
            '{0, 1,   0,   0,   319, 1},
            '{0, 1,   5,   2,   954, 1},
            '{0, 1, 320,   5,     0, 0},
            '{1, 0,   0,   0, 76480, 1},
            '{1, 0, 239, 319,   319, 1},
            '{1, 0, 240,   0,     0, 0},
            '{1, 1,   0,   0,     0, 1},
            '{1, 1,   5,   2,  1602, 1},
            '{2, 0,   0,   0, 76799, 1},
            '{2, 0,   5,   2, 76154, 1},
            '{3, 0,   0,   0,   319, 1},
            '{3, 0,  10,  20,  3499, 1},
            '{3, 0, 239,   0, 76799, 1},
            '{3, 0,   0, 320,     0, 0}
        };
        cur_m   = 0;
        cur_mir = 0;
        for (int i = 0; i < 18; i++) begin
            if (vt[i].m != cur_m || vt[i].mir != cur_mir) begin
                set_mode(vt[i].m, vt[i].mir);
                cur_m   = vt[i].m;
                cur_mir = vt[i].mir;
            end
            pix = 16'(16'h1000 + i * 37);
            run_vec(vt[i].h, vt[i].v, pix, a, ib, po, dv);
            n_assert++; if (a !== 17'(vt[i].addr)) begin n_fail++; $display("FAIL map%0d_addr: got %0d expected %0d", i, a, vt[i].addr); end
            n_assert++; if (ib !== 1'(vt[i].inb)) begin n_fail++; $display("FAIL map%0d_inb: got %0b expected %0d", i, ib, vt[i].inb); end
            n_assert++; if (po !== pix) begin n_fail++; $display("FAIL map%0d_pix: got %0h expected %0h", i, po, pix); end
            n_assert++; if (dv !== 1'b1) begin n_fail++; $display("FAIL map%0d_dv: got %0b expected 1", i, dv); end
        end
    endtask

    task automatic test_handshake();
        logic [16:0] a;
        logic ib, dv;
        logic [15:0] po;
        set_mode(0, 0);
        drive(100, 50, 16'hBEEF);
        mode_in     = 2'd1;
        mirror_in   = 1'b0;
        mode_req_in = 1'b1;
        cyc();
        idle();
        n_assert++; if (mode_busy_out !== 1'b1) begin n_fail++; $display("FAIL hs_busy_set: got %0b expected 1", mode_busy_out); end
        cyc();
        cyc();
        n_assert++; if (pixel_addr_out !== 17'd16100) begin n_fail++; $display("FAIL hs_req_pixel_addr: got %0d expected 16100", pixel_addr_out); end
        run_vec(319, 239, 16'h1234, a, ib, po, dv);
        n_assert++; if (a !== 17'd76799) begin n_fail++; $display("FAIL hs_midframe_addr: got %0d expected 76799", a); end
        n_assert++; if (mode_busy_out !== 1'b1) begin n_fail++; $display("FAIL hs_busy_hold: got %0b expected 1", mode_busy_out); end
        drive(0, 0, 16'h0F0F);
        cyc();
        idle();
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL hs_busy_clear: got %0b expected 0", mode_busy_out); end
        cyc();
        cyc();
        n_assert++; if (pixel_addr_out !== 17'd76480) begin n_fail++; $display("FAIL hs_frame_start_addr: got %0d expected 76480", pixel_addr_out); end
        run_vec(239, 319, 16'h5555, a, ib, po, dv);
        n_assert++; if (a !== 17'd319) begin n_fail++; $display("FAIL hs_newmode_addr: got %0d expected 319", a); end
    endtask

    task automatic test_coincident();
        logic [16:0] a;
        logic ib, dv;
        logic [15:0] po;
        drive(0, 0, 16'h0001);
        mode_in     = 2'd2;
        mirror_in   = 1'b0;
        mode_req_in = 1'b1;
        cyc();
        idle();
        n_assert++; if (mode_busy_out !== 1'b1) begin n_fail++; $display("FAIL coin_busy: got %0b expected 1", mode_busy_out); end
        cyc();
        cyc();
        n_assert++; if (pixel_addr_out !== 17'd76480) begin n_fail++; $display("FAIL coin_same_cycle_addr: got %0d expected 76480", pixel_addr_out); end
        run_vec(5, 2, 16'h0002, a, ib, po, dv);
        n_assert++; if (a !== 17'd74882) begin n_fail++; $display("FAIL coin_midframe_addr: got %0d expected 74882", a); end
        drive(0, 0, 16'h0003);
        cyc();
        idle();
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL coin_busy_clear: got %0b expected 0", mode_busy_out); end
        cyc();
        cyc();
        n_assert++; if (pixel_addr_out !== 17'd76799) begin n_fail++; $display("FAIL coin_applied_addr: got %0d expected 76799", pixel_addr_out); end
    endtask

    task automatic test_last_wins();
        idle();
        mode_in     = 2'd1;
        mirror_in   = 1'b0;
        mode_req_in = 1'b1;
        cyc();
        mode_in = 2'd3;
        cyc();
        idle();
        n_assert++; if (mode_busy_out !== 1'b1) begin n_fail++; $display("FAIL lw_busy: got %0b expected 1", mode_busy_out); end
        drive(0, 0, 16'h0004);
        cyc();
        idle();
        cyc();
        cyc();
        n_assert++; if (pixel_addr_out !== 17'd319) begin n_fail++; $display("FAIL lw_addr: got %0d expected 319", pixel_addr_out); end
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL lw_busy_clear: got %0b expected 0", mode_busy_out); end
    endtask

    task automatic test_back_to_back();
        logic        hist_v [40];
        logic [15:0] hist_p [40];
        idle();
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 40; i++) begin
            hcount_in     = 11'(1 + i);
            vcount_in     = 10'd3;
            data_valid_in = 1'($urandom_range(0, 1));
            pixel_in      = 16'($urandom);
            hist_v[i]     = data_valid_in;
            hist_p[i]     = pixel_in;
            cyc();
            if (i >= 2) begin
                n_assert++; if (data_valid_out !== hist_v[i-2]) begin n_fail++; $display("FAIL b2b%0d_dv: got %0b expected %0b", i, data_valid_out, hist_v[i-2]); end
                n_assert++; if (pixel_out !== hist_p[i-2]) begin n_fail++; $display("FAIL b2b%0d_pix: got %0h expected %0h", i, pixel_out, hist_p[i-2]); end
            end
        end
        idle();
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [16:0] a;
        logic ib, dv;
        logic [15:0] po;
        drive(10, 10, 16'hAAAA);
        mode_in     = 2'd1;
        mirror_in   = 1'b0;
        mode_req_in = 1'b1;
        cyc();
        mode_req_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(20 + i, 10, 16'hC000 + 16'(i));
            cyc();
        end
        n_assert++; if (data_valid_out !== 1'b1) begin n_fail++; $display("FAIL rst_pre_dv: got %0b expected 1", data_valid_out); end
        #2;
        rst_n_in = 1'b0;
        #1;
        n_assert++; if (data_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dv: got %0b expected 0", data_valid_out); end
        n_assert++; if (pixel_addr_out !== 17'd0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d expected 0", pixel_addr_out); end
        n_assert++; if (pixel_out !== 16'd0) begin n_fail++; $display("FAIL rst_mid_pix: got %0h expected 0", pixel_out); end
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0b expected 0", mode_busy_out); end
        idle();
        cyc();
        rst_n_in = 1'b1;
        cyc();
        cyc();
        n_assert++; if (data_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_post_dv: got %0b expected 0", data_valid_out); end
        n_assert++; if (mode_busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_post_busy: got %0b expected 0", mode_busy_out); end
        drive(0, 0, 16'h0077);
        cyc();
        idle();
        cyc();
        n_assert++; if (data_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_early_dv: got %0b expected 0", data_valid_out); end
        cyc();
        n_assert++; if (data_valid_out !== 1'b1) begin n_fail++; $display("FAIL rst_first_dv: got %0b expected 1", data_valid_out); end
        n_assert++; if (pixel_addr_out !== 17'd0) begin n_fail++; $display("FAIL rst_frame_start_addr: got %0d expected 0", pixel_addr_out); end
        run_vec(5, 2, 16'h0088, a, ib, po, dv);
        n_assert++; if (a !== 17'd645) begin n_fail++; $display("FAIL rst_mode_rot0_addr: got %0d expected 645", a); end
        n_assert++; if (po !== 16'h0088) begin n_fail++; $display("FAIL rst_mode_rot0_pix: got %0h expected 88", po); end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_handshake();
        test_coincident();
        test_last_wins();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_addr_gen.md
ROTATE_ADDR_GEN -- requirements
Module: rotate_addr_gen

Interface
REQ-001 SHALL have parameter SRC_W, default 320, meaning source frame width in pixels.
REQ-002 SHALL have parameter SRC_H, default 240, meaning source frame height in pixels.
REQ-003 SHALL have parameter PIXEL_W, default 16, meaning pixel data width.
REQ-004 SHALL have parameter ADDR_W, default $clog2(SRC_W*SRC_H) (17), meaning frame-buffer address width.
REQ-005 SHALL have port clk_in  input  1  system clock (65 MHz); one clock only.
REQ-006 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port hcount_in  input  11  output-view x coordinate.
REQ-008 SHALL have port vcount_in  input  10  output-view y coordinate.
REQ-009 SHALL have port data_valid_in  input  1  coordinate/pixel qualifier.
REQ-010 SHALL have port pixel_in  input  PIXEL_W  pixel riding with the coordinate.
REQ-011 SHALL have port mode_in  input  2  requested rotation: 0=ROT_0, 1=ROT_90, 2=ROT_180, 3=ROT_270.
REQ-012 SHALL have port mirror_in  input  1  requested horizontal mirror of the output view.
REQ-013 SHALL have port mode_req_in  input  1  single-cycle strobe capturing mode_in/mirror_in.
REQ-014 SHALL have port mode_busy_out  output  1  request captured, not yet applied.
REQ-015 SHALL have port pixel_out  output  PIXEL_W  pixel_in delayed to match address.
REQ-016 SHALL have port pixel_addr_out  output  ADDR_W  row-major source address (addr = row*SRC_W + col).
REQ-017 SHALL have port in_bounds_out  output  1  coordinate lies inside the rotated view.
REQ-018 SHALL have port data_valid_out  output  1  data_valid_in delayed.

Function
REQ-019 View size SHALL be VW=SRC_W, VH=SRC_H for ROT_0/ROT_180 and VW=SRC_H, VH=SRC_W for ROT_90/ROT_270.
REQ-020 With x=hcount_in, y=vcount_in, mirror SHALL replace x by VW-1-x before mapping.
REQ-021 Mapping SHALL be: ROT_0 row=y col=x; ROT_90 row=SRC_H-1-x col=y; ROT_180 row=SRC_H-1-y col=SRC_W-1-x; ROT_270 row=x col=SRC_W-1-y.
REQ-022 in_bounds SHALL be (x<VW)&&(y<VH) on unmirrored inputs; when 0, pixel_addr_out SHALL be 0.
REQ-023 Pipeline SHALL be 3 stages: S1 row/col/in_bounds, S2 row*SRC_W, S3 add col; all outputs registered, latency exactly 3 cycles, throughput 1 per cycle.
REQ-024 data_valid_out, pixel_out, in_bounds_out SHALL be delayed 3 cycles in lockstep with pixel_addr_out regardless of valid; no stalls.
REQ-025 Products SHALL be computed at ADDR_W width with no truncation for any in-bounds coordinate.
REQ-026 Mode handshake, two states IDLE/PENDING: mode_req_in captures mode_in/mirror_in into a shadow register and moves to PENDING; mode_busy_out=1 in PENDING.
REQ-027 PENDING->IDLE SHALL occur on a frame-start cycle (data_valid_in && hcount_in==0 && vcount_in==0); the active mode updates that edge and the frame-start pixel uses the new mode only if mode_req_in was captured in an earlier cycle.
REQ-028 mode_req_in coincident with frame start SHALL be captured and stay PENDING until the next frame start.
REQ-029 A new mode_req_in while PENDING SHALL overwrite the shadow; last request wins.
REQ-030 Active mode SHALL never change mid-frame.

Reset
REQ-031 On rst_n_in low, asynchronously: active mode ROT_0, mirror 0, state IDLE, all pipeline registers and outputs 0.
REQ-032 Reset mid-operation SHALL discard pending requests and in-flight pipeline data; data_valid_out stays 0 until 3 cycles after the first valid input post-reset.

Structure
REQ-033 Rotation enum (rot_mode_t) and mode-state enum SHALL live in shared package rotate_pkg.
REQ-034 One sub-module, rotate_mode_ctrl (handshake FSM plus active mode register), SHALL be instantiated; datapath stays in the top.

Verification
REQ-035 ROT_0, input (x=5,y=2) -> 3 cycles later addr=645, in_bounds=1, pixel_out=pixel_in.
REQ-036 ROT_90: (0,0) -> 76480; (239,319) -> 319; (240,0) -> in_bounds=0, addr=0.
REQ-037 ROT_180 (0,0) -> 76799; ROT_270 (0,0) -> 319; ROT_0 with mirror (0,0) -> 319.
REQ-038 mode_req_in ROT_90 at (100,50): busy=1, addresses stay ROT_0 through frame end; from next (0,0) addresses follow ROT_90, busy=0.
REQ-039 Back-to-back valid stream with random valid gaps: data_valid_out equals data_valid_in delayed exactly 3 cycles.
REQ-040 rst_n_in pulsed low mid-frame with request pending -> outputs 0 immediately, busy=0, mode ROT_0 after release.
